rgb_plane_arbiter: RTL and testbench
====================================

Name: rgb_plane_arbiter

Overview:
- Shares the three single-port 16384x8 colour-plane SRAMs (R, G, B) between two requesters.
- Requester 0 is the demosaic engine, which loads raw Bayer data and does 25-tap kernel fetches and write-back. Requester 1 is the host readout/DMA port.
- Arbitration is per cycle on plane-set conflicts, with a round-robin priority pointer and a bounded burst lock so the 25-read kernel fetch runs unbroken.
- Sits between the requesters and the three SRAM macros. Done sequencing stays in each requester.

Parameters:
- AW, 14, SRAM address width (16384 words).
- DW, 8, pixel data width.
- MAX_LOCK, 32, maximum consecutive locked grants before the priority pointer is forced to rotate (legal range 2..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_i[0:1]  in  1 each  access request; held with its attributes until gnt.
- we_i[0:1]  in  1 each  1 = write, 0 = read.
- plane_i[0:1]  in  2 each  0 = R, 1 = G, 2 = B, 3 = all planes (broadcast write).
- addr_i[0:1]  in  AW each  word address.
- wdata_i[0:1]  in  DW each  write data.
- lock_i[0:1]  in  1 each  request to keep priority for the next access.
- gnt_o[0:1]  out  1 each  access performed this cycle.
- rvalid_o[0:1]  out  1 each  read data valid (one cycle after the granted read).
- rdata_o[0:1]  out  DW each  read data.
- wr_r, wr_g, wr_b  out  1  SRAM write enables.
- addr_r, addr_g, addr_b  out  AW  SRAM addresses.
- wdata_r, wdata_g, wdata_b  out  DW  SRAM write data.
- rdata_r, rdata_g, rdata_b  in  DW  SRAM read data; synchronous, valid the cycle after the address.

Behaviour:
- Plane mask per request:
  - plane 0 → R; plane 1 → G; plane 2 → B.
  - plane 3 with we=1 → R+G+B.
  - plane 3 with we=0 is treated as plane 0 (R read).
- Registered state:
  - ptr (1 bit), the high-priority requester; reset 0.
  - lock_cnt, 8 bits; reset 0.
  - rv[0:1], read-valid pipeline; reset 0.
  - rsel[0:1], 2-bit plane select per requester for returning data; reset 0.
- Grant logic (combinational, same cycle):
  - H = ptr, L = ~ptr.
  - gnt[H] = req[H].
  - gnt[L] = req[L] && !(gnt[H] && (mask[H] & mask[L]) != 0).
  - Non-overlapping requests are both granted in the same cycle.
- SRAM drive:
  - Each plane is driven by the granted requester whose mask covers it: addr, wdata, and wr = we.
  - An undriven plane outputs addr 0, wdata 0, wr 0.
  - During reset, all gnt_o, wr_* are 0 and addr/wdata are 0.
- Read return:
  - A granted read sets rv[k] and rsel[k] = its plane.
  - Next cycle: rvalid_o[k] = 1 and rdata_o[k] = rdata of plane rsel[k].
  - rdata_o is 0 when rvalid_o is 0.
  - Back-to-back reads stream at one per cycle.
- Pointer update (each clock):
  - If req[H] && lock[H] && lock_cnt != MAX_LOCK-1: ptr holds, lock_cnt++.
  - Else if req[H]: ptr <= L, lock_cnt <= 0.
  - Else (H idle): ptr holds, lock_cnt <= 0.
  - L is never starved: at most MAX_LOCK consecutive grants to H while L waits.
- Simultaneous write and read of the same plane by different requesters cannot occur, because the masks conflict.
- Reset mid-operation:
  - All state clears immediately; any pending rvalid is dropped.
  - Requesters must reissue.

Decomposition:
- Shared package rgb_mem_pkg: PLANE_R/G/B/ALL encodings, AW, DW, and a plane-to-mask function. The demosaic core reuses these.
- One natural sub-module, rr2_lock_arb: the 2-way round-robin with lock counter (ptr, lock_cnt, grant equations).
- Muxing and the read-return pipeline stay in the top.

Test Plan:
1. req0 read, plane 1, addr 0x0105, ptr=0 → same cycle gnt0=1, addr_g=0x0105, wr_g=0. Next cycle rvalid0=1, rdata0 = rdata_g (drive 0xA5 → 0xA5).
2. req0 write R addr 7 data 0x11, and req1 write B addr 9 data 0x22, same cycle → both granted; wr_r=wr_b=1, wr_g=0, addr_g=0.
3. Both read G continuously, no lock, ptr=0 → grants alternate 0,1,0,1. Each rvalid is asserted one cycle after its own grant.
4. req1 broadcast write (plane 3) addr 0x3FFF data 0x80 while req0 reads B, ptr=0 → gnt0 only. Next cycle ptr=1, req1 granted, wr_r=wr_g=wr_b=1, all addr=0x3FFF.
5. req0 lock=1 with continuous R reads, req1 requesting R, MAX_LOCK=32 → req0 granted cycles 1–32, req1 granted on cycle 33.
6. Assert reset the cycle after a granted read → rvalid_o stays 0, all gnt/wr are 0, ptr=0. After release, a req1 read conflicting with req0 loses to req0.

Source files
------------

// File: rtl/rgb_mem_pkg.sv
// rtl/rgb_mem_pkg.sv - shared colour-plane memory encodings and helpers
package rgb_mem_pkg;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int NUM_PLANES = 3;

  typedef enum logic [1:0] {
    PLANE_R   = 2'd0,
    PLANE_G   = 2'd1,
    PLANE_B   = 2'd2,
    PLANE_ALL = 2'd3
  } plane_e;

  // Bit 0 = R, bit 1 = G, bit 2 = B. An all-planes read has no single
  // return plane, so it degrades to an R read.
  function automatic logic [2:0] plane_mask(input logic [1:0] plane, input logic we);
    logic [2:0] m;
    case (plane)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = we ? 3'b111 : 3'b001;
    endcase
    return m;
  endfunction

  // Plane whose SRAM output feeds the read return for a given request.
  function automatic logic [1:0] read_plane(input logic [1:0] plane);
    return (plane == 2'd3) ? 2'd0 : plane;
  endfunction

endpackage

// File: rtl/rr2_lock_arb.sv
// rtl/rr2_lock_arb.sv - two-way round-robin arbiter with bounded priority lock
module rr2_lock_arb #(
  parameter int MAX_LOCK = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic [2:0] mask0,
  input  logic [2:0] mask1,
  output logic [1:0] gnt
);

  localparam logic [7:0] LOCK_LAST = 8'(MAX_LOCK - 1);

  logic       ptr;
  logic [7:0] lock_cnt;
  logic       h_req;
  logic       l_req;
  logic       h_lock;
  logic [2:0] h_mask;
  logic [2:0] l_mask;
  logic       gnt_h;
  logic       gnt_l;

  // High-priority side always wins; low side only loses on a plane overlap.
  always_comb begin
    h_req  = ptr ? req[1]  : req[0];
    l_req  = ptr ? req[0]  : req[1];
    h_lock = ptr ? lock[1] : lock[0];
    h_mask = ptr ? mask1   : mask0;
    l_mask = ptr ? mask0   : mask1;
    gnt_h  = h_req & ~reset;
    gnt_l  = l_req & ~reset & ~(gnt_h & (|(h_mask & l_mask)));
    gnt    = ptr ? {gnt_h, gnt_l} : {gnt_l, gnt_h};
  end

  // Priority rotates after every high-side access unless it holds a lock,
  // and the lock is cut off after MAX_LOCK consecutive accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= 1'b0;
      lock_cnt <= 8'd0;
    end else if (h_req && h_lock && (lock_cnt != LOCK_LAST)) begin
      lock_cnt <= lock_cnt + 8'd1;
    end else if (h_req) begin
      ptr      <= ~ptr;
      lock_cnt <= 8'd0;
    end else begin
      lock_cnt <= 8'd0;
    end
  end

endmodule

// File: rtl/rgb_plane_arbiter.sv
// rtl/rgb_plane_arbiter.sv - shares the R/G/B plane SRAMs between demosaic and host
module rgb_plane_arbiter #(
  parameter int AW       = rgb_mem_pkg::AW,
  parameter int DW       = rgb_mem_pkg::DW,
  parameter int MAX_LOCK = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_i   [0:1],
  input  logic          we_i    [0:1],
  input  logic [1:0]    plane_i [0:1],
  input  logic [AW-1:0] addr_i  [0:1],
  input  logic [DW-1:0] wdata_i [0:1],
  input  logic          lock_i  [0:1],
  output logic          gnt_o    [0:1],
  output logic          rvalid_o [0:1],
  output logic [DW-1:0] rdata_o  [0:1],
  output logic          wr_r,
  output logic          wr_g,
  output logic          wr_b,
  output logic [AW-1:0] addr_r,
  output logic [AW-1:0] addr_g,
  output logic [AW-1:0] addr_b,
  output logic [DW-1:0] wdata_r,
  output logic [DW-1:0] wdata_g,
  output logic [DW-1:0] wdata_b,
  input  logic [DW-1:0] rdata_r,
  input  logic [DW-1:0] rdata_g,
  input  logic [DW-1:0] rdata_b
);

  import rgb_mem_pkg::*;

  logic [1:0]    req_v;
  logic [1:0]    lock_v;
  logic [2:0]    mask    [0:1];
  logic [1:0]    gnt;
  logic [2:0]    p_wr;
  logic [AW-1:0] p_addr  [0:2];
  logic [DW-1:0] p_wdata [0:2];
  logic [1:0]    rv;
  logic [1:0]    rsel    [0:1];

  // Per-requester plane masks and packed request/lock vectors for the arbiter.
  always_comb begin
    req_v  = {req_i[1], req_i[0]};
    lock_v = {lock_i[1], lock_i[0]};
    for (int k = 0; k < 2; k++) begin
      mask[k] = plane_mask(plane_i[k], we_i[k]);
    end
  end

  rr2_lock_arb #(
    .MAX_LOCK (MAX_LOCK)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_v),
    .lock  (lock_v),
    .mask0 (mask[0]),
    .mask1 (mask[1]),
    .gnt   (gnt)
  );

  assign gnt_o[0] = gnt[0];
  assign gnt_o[1] = gnt[1];

  // Each plane follows whichever granted requester covers it; grants never
  // overlap on a plane, so the order of the two checks does not matter.
  always_comb begin
    p_wr = 3'b000;
    for (int p = 0; p < NUM_PLANES; p++) begin
      p_addr[p]  = '0;
      p_wdata[p] = '0;
      if (gnt[0] && mask[0][p]) begin
        p_wr[p]    = we_i[0];
        p_addr[p]  = addr_i[0];
        p_wdata[p] = wdata_i[0];
      end else if (gnt[1] && mask[1][p]) begin
        p_wr[p]    = we_i[1];
        p_addr[p]  = addr_i[1];
        p_wdata[p] = wdata_i[1];
      end
    end
  end

  assign wr_r    = p_wr[0];
  assign wr_g    = p_wr[1];
  assign wr_b    = p_wr[2];
  assign addr_r  = p_addr[0];
  assign addr_g  = p_addr[1];
  assign addr_b  = p_addr[2];
  assign wdata_r = p_wdata[0];
  assign wdata_g = p_wdata[1];
  assign wdata_b = p_wdata[2];

  // Remember which granted reads are in flight and which plane answers them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv      <= 2'b00;
      rsel[0] <= 2'd0;
      rsel[1] <= 2'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        rv[k] <= gnt[k] & ~we_i[k];
        if (gnt[k] && !we_i[k]) begin
          rsel[k] <= read_plane(plane_i[k]);
        end
      end
    end
  end

  // Steer the SRAM output of the selected plane back; zero when not valid.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rvalid_o[k] = rv[k];
      rdata_o[k]  = '0;
      if (rv[k]) begin
        case (rsel[k])
          2'd0:    rdata_o[k] = rdata_r;
          2'd1:    rdata_o[k] = rdata_g;
          2'd2:    rdata_o[k] = rdata_b;
          default: rdata_o[k] = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb_plane_arbiter.sv
// tb/tb_rgb_plane_arbiter.sv - directed self-checking bench for rgb_plane_arbiter
module tb_rgb_plane_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          req_i   [0:1];
  logic          we_i    [0:1];
  logic [1:0]    plane_i [0:1];
  logic [AW-1:0] addr_i  [0:1];
  logic [DW-1:0] wdata_i [0:1];
  logic          lock_i  [0:1];
  logic          gnt_o    [0:1];
  logic          rvalid_o [0:1];
  logic [DW-1:0] rdata_o  [0:1];
  logic          wr_r, wr_g, wr_b;
  logic [AW-1:0] addr_r, addr_g, addr_b;
  logic [DW-1:0] wdata_r, wdata_g, wdata_b;
  logic [DW-1:0] rdata_r, rdata_g, rdata_b;

  int checks;
  int errors;

  rgb_plane_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(32)) dut (
    .clk(clk), .reset(reset),
    .req_i(req_i), .we_i(we_i), .plane_i(plane_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .lock_i(lock_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
    .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
    .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
    .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      req_i[k] = 1'b0; we_i[k] = 1'b0; plane_i[k] = 2'd0;
      addr_i[k] = '0; wdata_i[k] = '0; lock_i[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_i[0] = 1'b1; we_i[0] = 1'b1; plane_i[0] = 2'd0; addr_i[0] = 14'h0123; wdata_i[0] = 8'h77;
    req_i[1] = 1'b1; we_i[1] = 1'b0; plane_i[1] = 2'd1; addr_i[1] = 14'h0005;
    #2;
    checks++; if (gnt_o[0] !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %0h exp 0", gnt_o[0]); end
    checks++; if (gnt_o[1] !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got %0h exp 0", gnt_o[1]); end
    checks++; if (wr_r !== 1'b0) begin errors++; $display("FAIL rst_wr_r got %0h exp 0", wr_r); end
    checks++; if (addr_r !== 14'h0) begin errors++; $display("FAIL rst_addr_r got %0h exp 0", addr_r); end
    checks++; if (wdata_r !== 8'h0) begin errors++; $display("FAIL rst_wdata_r got %0h exp 0", wdata_r); end
    checks++; if (addr_g !== 14'h0) begin errors++; $display("FAIL rst_addr_g got %0h exp 0", addr_g); end
    tick();
    checks++; if (rvalid_o[0] !== 1'b0 || rvalid_o[1] !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0h%0h exp 00", rvalid_o[0], rvalid_o[1]); end
    checks++; if (rdata_o[0] !== 8'h0) begin errors++; $display("FAIL rst_rdata0 got %0h exp 0", rdata_o[0]); end
    idle_all();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    req_i[0] = 1'b1; we_i[0] = 1'b0; plane_i[0] = 2'd1; addr_i[0] = 14'h0105;
    @(negedge clk);
    checks++; if (gnt_o[0] !== 1'b1) begin errors++; $display("FAIL rd_gnt0 got %0h exp 1", gnt_o[0]); end
    checks++; if (addr_g !== 14'h0105) begin errors++; $display("FAIL rd_addr_g got %0h exp 105", addr_g); end
    checks++; if (wr_g !== 1'b0) begin errors++; $display("FAIL rd_wr_g got %0h exp 0", wr_g); end
    checks++; if (addr_r !== 14'h0) begin errors++; $display("FAIL rd_addr_r got %0h exp 0", addr_r); end
    tick();
    idle_all();
    @(negedge clk);
    checks++; if (rvalid_o[0] !== 1'b1) begin errors++; $display("FAIL rd_rvalid0 got %0h exp 1", rvalid_o[0]); end
    checks++; if (rdata_o[0] !== 8'hA5) begin errors++; $display("FAIL rd_rdata0 got %0h exp a5", rdata_o[0]); end
    checks++; if (rvalid_o[1] !== 1'b0) begin errors++; $display("FAIL rd_rvalid1 got %0h exp 0", rvalid_o[1]); end
    tick();
    @(negedge clk);
    checks++; if (rvalid_o[0] !== 1'b0) begin errors++; $display("FAIL rd_rvalid0_drop got %0h exp 0", rvalid_o[0]); end
    tick();
  endtask

  task automatic test_dual_write();
    do_reset();
    req_i[0] = 1'b1; we_i[0] = 1'b1; plane_i[0] = 2'd0; addr_i[0] = 14'd7; wdata_i[0] = 8'h11;
    req_i[1] = 1'b1; we_i[1] = 1'b1; plane_i[1] = 2'd2; addr_i[1] = 14'd9; wdata_i[1] = 8'h22;
    @(negedge clk);
    checks++; if (gnt_o[0] !== 1'b1 || gnt_o[1] !== 1'b1) begin errors++; $display("FAIL dw_gnt got %0h%0h exp 11", gnt_o[0], gnt_o[1]); end
    checks++; if ({wr_r, wr_g, wr_b} !== 3'b101) begin errors++; $display("FAIL dw_wr got %0b exp 101", {wr_r, wr_g, wr_b}); end
    checks++; if (addr_g !== 14'h0) begin errors++; $display("FAIL dw_addr_g got %0h exp 0", addr_g); end
    checks++; if (addr_r !== 14'd7 || wdata_r !== 8'h11) begin errors++; $display("FAIL dw_r got %0h/%0h exp 7/11", addr_r, wdata_r); end
    checks++; if (addr_b !== 14'd9 || wdata_b !== 8'h22) begin errors++; $display("FAIL dw_b got %0h/%0h exp 9/22", addr_b, wdata_b); end
    tick();
    idle_all();
    @(negedge clk);
    checks++; if (rvalid_o[0] !== 1'b0 || rvalid_o[1] !== 1'b0) begin errors++; $display("FAIL dw_rvalid got %0h%0h exp 00", rvalid_o[0], rvalid_o[1]); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp0;
    do_reset();
    req_i[0] = 1'b1; we_i[0] = 1'b0; plane_i[0] = 2'd1; addr_i[0] = 14'h0010;
    req_i[1] = 1'b1; we_i[1] = 1'b0; plane_i[1] = 2'd1; addr_i[1] = 14'h0020;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp0 = ((i % 2) == 0);
      checks++; if (gnt_o[0] !== exp0 || gnt_o[1] !== !exp0) begin errors++; $display("FAIL b2b_gnt[%0d] got %0h%0h exp %0h%0h", i, gnt_o[0], gnt_o[1], exp0, !exp0); end
      checks++; if (addr_g !== (exp0 ? 14'h0010 : 14'h0020)) begin errors++; $display("FAIL b2b_addr_g[%0d] got %0h exp %0h", i, addr_g, exp0 ? 14'h0010 : 14'h0020); end
      if (i > 0) begin
        checks++; if (rvalid_o[0] !== !exp0 || rvalid_o[1] !== exp0) begin errors++; $display("FAIL b2b_rvalid[%0d] got %0h%0h exp %0h%0h", i, rvalid_o[0], rvalid_o[1], !exp0, exp0); end
        checks++; if (rdata_o[exp0 ? 1 : 0] !== 8'hA5) begin errors++; $display("FAIL b2b_rdata[%0d] got %0h exp a5", i, rdata_o[exp0 ? 1 : 0]); end
      end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_broadcast();
    do_reset();
    req_i[0] = 1'b1; we_i[0] = 1'b0; plane_i[0] = 2'd2; addr_i[0] = 14'h0044;
    req_i[1] = 1'b1; we_i[1] = 1'b1; plane_i[1] = 2'd3; addr_i[1] = 14'h3FFF; wdata_i[1] = 8'h80;
    @(negedge clk);
    checks++; if (gnt_o[0] !== 1'b1 || gnt_o[1] !== 1'b0) begin errors++; $display("FAIL bc_gnt_a got %0h%0h exp 10", gnt_o[0], gnt_o[1]); end
    checks++; if (addr_b !== 14'h0044 || wr_b !== 1'b0) begin errors++; $display("FAIL bc_b_a got %0h/%0h exp 44/0", addr_b, wr_b); end
    checks++; if (addr_r !== 14'h0 || wr_r !== 1'b0) begin errors++; $display("FAIL bc_r_a got %0h/%0h exp 0/0", addr_r, wr_r); end
    tick();
    req_i[0] = 1'b0;
    @(negedge clk);
    checks++; if (gnt_o[0] !== 1'b0 || gnt_o[1] !== 1'b1) begin errors++; $display("FAIL bc_gnt_b got %0h%0h exp 01", gnt_o[0], gnt_o[1]); end
    checks++; if ({wr_r, wr_g, wr_b} !== 3'b111) begin errors++; $display("FAIL bc_wr got %0b exp 111", {wr_r, wr_g, wr_b}); end
    checks++; if (addr_r !== 14'h3FFF || addr_g !== 14'h3FFF || addr_b !== 14'h3FFF) begin errors++; $display("FAIL bc_addr got %0h/%0h/%0h exp 3fff", addr_r, addr_g, addr_b); end
    checks++; if (wdata_r !== 8'h80 || wdata_g !== 8'h80 || wdata_b !== 8'h80) begin errors++; $display("FAIL bc_wdata got %0h/%0h/%0h exp 80", wdata_r, wdata_g, wdata_b); end
    checks++; if (rvalid_o[0] !== 1'b1 || rdata_o[0] !== 8'hC3) begin errors++; $display("FAIL bc_rdata0 got %0h/%0h exp 1/c3", rvalid_o[0], rdata_o[0]); end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    req_i[0] = 1'b1; we_i[0] = 1'b0; plane_i[0] = 2'd0; addr_i[0] = 14'd1; lock_i[0] = 1'b1;
    req_i[1] = 1'b1; we_i[1] = 1'b0; plane_i[1] = 2'd0; addr_i[1] = 14'd2;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      checks++;
      if (gnt_o[0] !== (c <= 32) || gnt_o[1] !== (c == 33)) begin
        errors++;
        $display("FAIL lock_gnt[%0d] got %0h%0h exp %0h%0h", c, gnt_o[0], gnt_o[1], (c <= 32), (c == 33));
      end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i[0] = 1'b1; we_i[0] = 1'b0; plane_i[0] = 2'd0; addr_i[0] = 14'd5;
    @(negedge clk);
    checks++; if (gnt_o[0] !== 1'b1 || addr_r !== 14'd5) begin errors++; $display("FAIL rm_gnt0 got %0h/%0h exp 1/5", gnt_o[0], addr_r); end
    tick();
    idle_all();
    reset = 1'b1;
    req_i[1] = 1'b1; we_i[1] = 1'b1; plane_i[1] = 2'd2; addr_i[1] = 14'd3; wdata_i[1] = 8'h44;
    #1;
    checks++; if (rvalid_o[0] !== 1'b0) begin errors++; $display("FAIL rm_rvalid0 got %0h exp 0", rvalid_o[0]); end
    checks++; if (gnt_o[1] !== 1'b0 || wr_b !== 1'b0 || addr_b !== 14'h0) begin errors++; $display("FAIL rm_gate got %0h/%0h/%0h exp 0/0/0", gnt_o[1], wr_b, addr_b); end
    tick();
    reset = 1'b0;
    req_i[0] = 1'b1; we_i[0] = 1'b0; plane_i[0] = 2'd0; addr_i[0] = 14'h000A;
    req_i[1] = 1'b1; we_i[1] = 1'b0; plane_i[1] = 2'd3; addr_i[1] = 14'h000B; wdata_i[1] = 8'h00;
    @(negedge clk);
    checks++; if (gnt_o[0] !== 1'b1 || gnt_o[1] !== 1'b0) begin errors++; $display("FAIL rm_gnt_post got %0h%0h exp 10", gnt_o[0], gnt_o[1]); end
    checks++; if (addr_r !== 14'h000A || rvalid_o[0] !== 1'b0) begin errors++; $display("FAIL rm_addr_post got %0h/%0h exp a/0", addr_r, rvalid_o[0]); end
    tick();
    req_i[0] = 1'b0;
    @(negedge clk);
    checks++; if (gnt_o[1] !== 1'b1 || addr_r !== 14'h000B || wr_r !== 1'b0) begin errors++; $display("FAIL rm_gnt1 got %0h/%0h/%0h exp 1/b/0", gnt_o[1], addr_r, wr_r); end
    checks++; if (rvalid_o[0] !== 1'b1 || rdata_o[0] !== 8'h3C) begin errors++; $display("FAIL rm_rdata0 got %0h/%0h exp 1/3c", rvalid_o[0], rdata_o[0]); end
    tick();
    req_i[1] = 1'b0;
    @(negedge clk);
    checks++; if (rvalid_o[1] !== 1'b1 || rdata_o[1] !== 8'h3C) begin errors++; $display("FAIL rm_rdata1 got %0h/%0h exp 1/3c", rvalid_o[1], rdata_o[1]); end
    checks++; if (rvalid_o[0] !== 1'b0 || rdata_o[0] !== 8'h00) begin errors++; $display("FAIL rm_rdata0_idle got %0h/%0h exp 0/0", rvalid_o[0], rdata_o[0]); end
    tick();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    rdata_r = 8'h3C;
    rdata_g = 8'hA5;
    rdata_b = 8'hC3;
    idle_all();
    test_reset();
    test_single_read();
    test_dual_write();
    test_back_to_back();
    test_broadcast();
    test_lock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
